// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register pair.
// Fixed WIDTH+1 cycle latency; MTHI/MTLO pass through while idle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             WE_HI,
  output logic             WE_LO,
  output logic [WIDTH-1:0] HI_in,
  output logic [WIDTH-1:0] LO_in
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic               sa_r;
  logic               sb_r;
  logic               div0_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH:0]   mul_sh;
  logic [WIDTH:0]     rsh;
  logic [WIDTH:0]     rsub;
  logic               qbit;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign sa = ~op[0] & a[WIDTH-1];
  assign sb = ~op[0] & b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  // acc_r holds {hi,lo} of the product, or {rem,quo} while dividing
  always_comb begin
    add_sum = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
            + (acc_r[0] ? {1'b0, opnd_r} : '0);
    mul_sh  = {add_sum, acc_r[WIDTH-1:0]};
    rsh     = acc_r[2*WIDTH-1:WIDTH-1];
    rsub    = rsh - {1'b0, opnd_r};
    qbit    = rsh >= {1'b0, opnd_r};
    if (op_r[1])
      acc_nx = {qbit ? rsub[WIDTH-1:0] : rsh[WIDTH-1:0],
                acc_r[WIDTH-2:0], qbit};
    else
      acc_nx = mul_sh[2*WIDTH:1];
  end

  always_comb begin
    prod = (op_r == 2'b00 && (sa_r ^ sb_r)) ? -acc_nx : acc_nx;
    quo  = acc_nx[WIDTH-1:0];
    rem  = acc_nx[2*WIDTH-1:WIDTH];
    if (op_r[1]) begin
      fin_lo = div0_r ? '1
             : (op_r[0] == 1'b0 && (sa_r ^ sb_r)) ? -quo : quo;
      fin_hi = (op_r[0] == 1'b0 && sa_r) ? -rem : rem;
    end else begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt    <= '0;
      op_r   <= '0;
      sa_r   <= 1'b0;
      sb_r   <= 1'b0;
      div0_r <= 1'b0;
      opnd_r <= '0;
      acc_r  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_r   <= op;
          sa_r   <= sa;
          sb_r   <= sb;
          div0_r <= (b == '0);
          cnt    <= '0;
          opnd_r <= op[1] ? mb : ma;
          acc_r  <= {{WIDTH{1'b0}}, op[1] ? ma : mb};
        end
        CALC: begin
          acc_r <= acc_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi_r <= fin_hi;
            lo_r <= fin_lo;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    WE_HI = 1'b0;
    WE_LO = 1'b0;
    HI_in = '0;
    LO_in = '0;
    unique case (state)
      IDLE: begin
        if (clr && mthi) begin
          WE_HI = 1'b1;
          HI_in = mt_data;
        end
        if (clr && mtlo) begin
          WE_LO = 1'b1;
          LO_in = mt_data;
        end
      end
      CALC: busy = 1'b1;
      DONE: begin
        busy  = 1'b1;
        done  = 1'b1;
        WE_HI = 1'b1;
        WE_LO = 1'b1;
        HI_in = hi_r;
        LO_in = lo_r;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit directly upstream of the CPU's HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU over a fixed 33-cycle latency.
- Forwards MTHI/MTLO writes, producing the HI/LO write-enable and write-data signals that the HI/LO register consumes.
- Asserts busy while working so the pipeline stalls MFHI/MFLO and new HI/LO operations.

Parameters:
WIDTH, 32, operand and HI/LO register width; iteration count equals WIDTH

Ports:
clk  input  1  clock, rising edge
clr  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
mthi  input  1  MTHI request
mtlo  input  1  MTLO request
mt_data  input  WIDTH  MTHI/MTLO source value
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result valid
WE_HI  output  1  HI write enable
WE_LO  output  1  LO write enable
HI_in  output  WIDTH  value for HI
LO_in  output  WIDTH  value for LO

Behaviour:
- Reset: clr low asynchronously forces IDLE, counter = 0, internal result registers = 0. Outputs busy, done, WE_HI, WE_LO, HI_in, LO_in all go to 0. Reset mid-operation discards the partial result and no write occurs.
- States: IDLE, CALC, DONE.
- IDLE -> CALC: on an edge E0 with start = 1.
  - Latch op, the sign flags of a and b, and magnitudes |a|, |b|. Signed ops take two's-complement magnitude; unsigned ops take raw values.
  - Counter = 0.
- CALC: one iteration per edge, on E1..E32 (WIDTH edges).
  - Multiply: shift-add on the 2*WIDTH product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - At counter = WIDTH-1, the next edge goes to DONE.
- DONE: lasts exactly one cycle (between E32 and E33).
  - done = 1, WE_HI = 1, WE_LO = 1.
  - HI_in/LO_in driven from registered results, so the HI/LO register captures them on E33.
  - E33 -> IDLE.
- busy = 1 in CALC and DONE; 0 in IDLE.
- start while busy: ignored, no queuing.
- Result rules:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH product. MULT negates the product if operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor 0, any divide op: LO = all ones, HI = a. Normal latency applies.
- MTHI/MTLO in IDLE: combinational same-cycle pass-through.
  - mthi -> WE_HI = 1, HI_in = mt_data.
  - mtlo -> WE_LO = 1, LO_in = mt_data.
  - mthi and mtlo together assert both enables.
  - start together with mthi/mtlo: the MT write occurs this cycle and the operation is also accepted.
- mthi/mtlo while busy: ignored. The pipeline must stall on busy.
- Outside DONE and MT cycles: WE_HI = WE_LO = 0, HI_in = LO_in = 0.

Test Plan:
- MULT a = 0xFFFFFFFD, b = 7 -> busy for 33 cycles; DONE with HI_in = 0xFFFFFFFF, LO_in = 0xFFFFFFEB; both WEs high for exactly one cycle.
- MULTU a = b = 0xFFFFFFFF -> HI_in = 0xFFFFFFFE, LO_in = 0x00000001. Back-to-back start in the cycle after done is accepted.
- DIV a = 0xFFFFFFF9 (-7), b = 2 -> LO_in = 0xFFFFFFFD, HI_in = 0xFFFFFFFF. DIVU a = 100, b = 7 -> LO_in = 14, HI_in = 2.
- DIVU a = 0x1234, b = 0 -> LO_in = 0xFFFFFFFF, HI_in = 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> LO_in = 0x80000000, HI_in = 0.
- MTHI mt_data = 0xCAFEF00D in IDLE -> WE_HI = 1, HI_in = 0xCAFEF00D in the same cycle, WE_LO = 0. mthi while busy and start pulses while busy -> no effect; the first result is unchanged.
- Start MULT, drive clr low at cycle 10 -> busy, done and WEs drop to 0 immediately with no write. After release, a new DIVU 9/3 gives LO_in = 3, HI_in = 0.
